reg_bank_gen: RTL and testbench

- Parametrised successor to the 8088 register bank. Provides byte-splittable general registers (xL/xH/xX views) plus full-width pointer registers.
- Adds a REQ/ACK handshake FSM, registered read data, and auto-increment/auto-decrement pointer modes (stack/string-style access). The address-unit side can push and pop through one port.
- Sits between the bus interface unit and the internal DATA bus. Drives DATA only during a read acknowledge.

---
 rtl/reg_bank_gen.sv | 262 ++++++++++++++++++++++++++
 tb/tb_reg_bank_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_gen.sv
// ----------------------------------------------------------------------------
// reg_bank_gen
//   Parametrised 8088-style register bank. It holds NUM_GP byte-splittable
//   general registers (xL / xH / xX views) and NUM_WIDE full-width pointer
//   registers. Each transaction is a REQ/ACK handshake through a three-state
//   FSM (IDLE -> EXEC -> RESP). Pointer registers support post-increment and
//   pre-decrement access for stack/string style use.
//
// Ports
//   CLK   in   clock, all state changes on the rising edge
//   RST   in   synchronous active-high reset, highest priority
//   REQ   in   transaction request, level, held until ACK is seen
//   WR    in   1 = write, 0 = read, captured with REQ
//   MODE  in   00 plain, 01 post-increment, 10 pre-decrement, 11 reserved
//   SEL   in   register select (xL, xH, xX, then pointer registers)
//   DATA  io   write data in; read data out only during a read acknowledge
//   ACK   out  transaction done
//   ERR   out  qualifies ACK: illegal select or mode
// ----------------------------------------------------------------------------
module reg_bank_gen #(
    parameter int DATA_W   = 16,
    parameter int NUM_GP   = 4,
    parameter int NUM_WIDE = 4,
    parameter int SEL_W    = 4,
    parameter int STEP     = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WR,
    input  logic [1:0]        MODE,
    input  logic [SEL_W-1:0]  SEL,
    inout  wire  [DATA_W-1:0] DATA,
    output logic              ACK,
    output logic              ERR
);

    localparam int HALF_W = DATA_W / 2;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    localparam logic [1:0] MODE_PLAIN   = 2'b00;
    localparam logic [1:0] MODE_POSTINC = 2'b01;
    localparam logic [1:0] MODE_PREDEC  = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

    // FSM and captured request
    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              wr_q, wr_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Register file: general registers split into byte lanes
    logic [HALF_W-1:0] gp_lo_q [NUM_GP];
    logic [HALF_W-1:0] gp_lo_d [NUM_GP];
    logic [HALF_W-1:0] gp_hi_q [NUM_GP];
    logic [HALF_W-1:0] gp_hi_d [NUM_GP];
    logic [DATA_W-1:0] wide_q  [NUM_WIDE];
    logic [DATA_W-1:0] wide_d  [NUM_WIDE];

    // Response path
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              errdec_q, errdec_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              drive_q, drive_d;

    // Select decode
    logic [NUM_GP-1:0]   hit_lo_s;
    logic [NUM_GP-1:0]   hit_hi_s;
    logic [NUM_GP-1:0]   hit_full_s;
    logic [NUM_WIDE-1:0] hit_wide_s;
    logic                legal_s;
    logic                wide_sel_s;
    logic                bad_s;

    // One-hot decode of the captured select into the four register views
    always_comb begin
        hit_lo_s   = '0;
        hit_hi_s   = '0;
        hit_full_s = '0;
        hit_wide_s = '0;
        for (int i = 0; i < NUM_GP; i++) begin
            hit_lo_s[i]   = (sel_q == SEL_W'(i));
            hit_hi_s[i]   = (sel_q == SEL_W'(NUM_GP + i));
            hit_full_s[i] = (sel_q == SEL_W'(2 * NUM_GP + i));
        end
        for (int j = 0; j < NUM_WIDE; j++) begin
            hit_wide_s[j] = (sel_q == SEL_W'(3 * NUM_GP + j));
        end
    end

    assign legal_s    = |{hit_lo_s, hit_hi_s, hit_full_s, hit_wide_s};
    assign wide_sel_s = |hit_wide_s;
    // Pointer modes are only meaningful on the full-width pointer registers
    assign bad_s      = !legal_s || (mode_q == MODE_RSVD) ||
                        ((mode_q != MODE_PLAIN) && !wide_sel_s);

    // Next-state logic: FSM, request capture, register access, response flags
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wr_d     = wr_q;
        mode_d   = mode_q;
        wdata_d  = wdata_q;
        gp_lo_d  = gp_lo_q;
        gp_hi_d  = gp_hi_q;
        wide_d   = wide_q;
        rdata_d  = rdata_q;
        errdec_d = errdec_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        drive_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    sel_d   = SEL;
                    wr_d    = WR;
                    mode_d  = MODE;
                    wdata_d = DATA;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXEC: begin
                errdec_d = bad_s;
                rdata_d  = '0;
                if (!bad_s) begin
                    for (int i = 0; i < NUM_GP; i++) begin
                        if (hit_lo_s[i]) begin
                            if (wr_q) begin
                                gp_lo_d[i] = wdata_q[HALF_W-1:0];
                            end else begin
                                rdata_d = {{HALF_W{1'b0}}, gp_lo_q[i]};
                            end
                        end else if (hit_hi_s[i]) begin
                            // xH writes take the byte from the low data lane
                            if (wr_q) begin
                                gp_hi_d[i] = wdata_q[HALF_W-1:0];
                            end else begin
                                rdata_d = {{HALF_W{1'b0}}, gp_hi_q[i]};
                            end
                        end else if (hit_full_s[i]) begin
                            if (wr_q) begin
                                gp_hi_d[i] = wdata_q[DATA_W-1:HALF_W];
                                gp_lo_d[i] = wdata_q[HALF_W-1:0];
                            end else begin
                                rdata_d = {gp_hi_q[i], gp_lo_q[i]};
                            end
                        end else begin
                            rdata_d = rdata_d;
                        end
                    end
                    for (int j = 0; j < NUM_WIDE; j++) begin
                        if (hit_wide_s[j]) begin
                            case (mode_q)
                                MODE_PLAIN: begin
                                    if (wr_q) begin
                                        wide_d[j] = wdata_q;
                                    end else begin
                                        rdata_d = wide_q[j];
                                    end
                                end
                                MODE_POSTINC: begin
                                    if (wr_q) begin
                                        wide_d[j] = wdata_q + STEP_V;
                                    end else begin
                                        rdata_d   = wide_q[j];
                                        wide_d[j] = wide_q[j] + STEP_V;
                                    end
                                end
                                MODE_PREDEC: begin
                                    // A write overrides the decrement outright
                                    if (wr_q) begin
                                        wide_d[j] = wdata_q;
                                    end else begin
                                        rdata_d   = wide_q[j] - STEP_V;
                                        wide_d[j] = wide_q[j] - STEP_V;
                                    end
                                end
                                default: begin
                                    wide_d[j] = wide_q[j];
                                end
                            endcase
                        end else begin
                            wide_d[j] = wide_q[j];
                        end
                    end
                end else begin
                    rdata_d = '0;
                end
                state_d = ST_RESP;
            end

            ST_RESP: begin
                // ACK is held for as long as the requester keeps REQ high
                if (REQ) begin
                    ack_d   = 1'b1;
                    err_d   = errdec_q;
                    drive_d = !wr_q && !errdec_q;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            wr_q     <= 1'b0;
            mode_q   <= 2'b00;
            wdata_q  <= '0;
            rdata_q  <= '0;
            errdec_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            drive_q  <= 1'b0;
            for (int i = 0; i < NUM_GP; i++) begin
                gp_lo_q[i] <= '0;
                gp_hi_q[i] <= '0;
            end
            for (int j = 0; j < NUM_WIDE; j++) begin
                wide_q[j] <= '0;
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            wr_q     <= wr_d;
            mode_q   <= mode_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            errdec_q <= errdec_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            drive_q  <= drive_d;
            gp_lo_q  <= gp_lo_d;
            gp_hi_q  <= gp_hi_d;
            wide_q   <= wide_d;
        end
    end

    assign DATA = drive_q ? rdata_q : {DATA_W{1'bz}};
    assign ACK  = ack_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_reg_bank_gen.sv
// ----------------------------------------------------------------------------
// tb_reg_bank_gen
//   Self-checking bench for reg_bank_gen with default parameters. Expected
//   responses are queued when a request is driven and popped when ACK rises.
//   DATA is a pulled-up net, so a released bus reads all ones.
// ----------------------------------------------------------------------------
module tb_reg_bank_gen;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ;
    logic        WR;
    logic [1:0]  MODE;
    logic [3:0]  SEL;
    tri1  [15:0] DATA;
    logic        ACK;
    logic        ERR;

    logic        tb_drv;
    logic [15:0] tb_dat;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] REL = 16'hFFFF;

    typedef struct {
        logic        wr;
        logic [1:0]  mode;
        logic [3:0]  sel;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        logic        exp_err;
    } txn_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q [$];

    assign DATA = tb_drv ? tb_dat : 16'hzzzz;

    always #5 CLK = ~CLK;

    reg_bank_gen dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
        .WR   (WR),
        .MODE (MODE),
        .SEL  (SEL),
        .DATA (DATA),
        .ACK  (ACK),
        .ERR  (ERR)
    );

    function automatic txn_t mk(input logic wr, input logic [1:0] mode,
                                input logic [3:0] sel, input logic [15:0] wd,
                                input logic [15:0] ed, input logic ee);
        txn_t t;
        t.wr = wr; t.mode = mode; t.sel = sel; t.wdata = wd;
        t.exp_data = ed; t.exp_err = ee;
        return t;
    endfunction

    // Drive a request and record what the response should look like
    task automatic start_txn(input txn_t t);
        exp_t e;
        @(negedge CLK);
        REQ = 1'b1; WR = t.wr; MODE = t.mode; SEL = t.sel;
        tb_dat = t.wdata; tb_drv = t.wr;
        e.data = t.exp_data; e.err = t.exp_err;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for ACK; lat counts rising edges after the sampling edge
    task automatic wait_ack(output int lat, output logic [15:0] d, output logic e);
        @(posedge CLK); #1;
        tb_drv = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(posedge CLK); #1;
            lat++;
            if (ACK === 1'b1) break;
        end
        d = DATA;
        e = ERR;
    endtask

    task automatic drop_req();
        @(negedge CLK);
        REQ = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; REQ = 1'b0; WR = 1'b0; MODE = 2'b00; SEL = 4'd0;
        tb_drv = 1'b0; tb_dat = 16'h0000;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (ACK !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ACK); end
        total++; if (ERR !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", ERR); end
        total++; if (DATA !== REL) begin bad++; $display("FAIL reset_data: got %h want %h", DATA, REL); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_byte_lanes();
        txn_t tbl [$];
        int lat; logic [15:0] d; logic e; exp_t ex;
        tbl.push_back(mk(1'b0, 2'b00, 4'd8,  16'h0000, 16'h0000, 1'b0));
        tbl.push_back(mk(1'b1, 2'b00, 4'd8,  16'h1234, REL,      1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd0,  16'h0000, 16'h0034, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd4,  16'h0000, 16'h0012, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd8,  16'h0000, 16'h1234, 1'b0));
        tbl.push_back(mk(1'b1, 2'b00, 4'd9,  16'h5566, REL,      1'b0));
        tbl.push_back(mk(1'b1, 2'b00, 4'd1,  16'h00AB, REL,      1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd9,  16'h0000, 16'h55AB, 1'b0));
        tbl.push_back(mk(1'b1, 2'b00, 4'd7,  16'h00CD, REL,      1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd11, 16'h0000, 16'hCD00, 1'b0));
        tbl.push_back(mk(1'b1, 2'b00, 4'd10, 16'hA55A, REL,      1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd2,  16'h0000, 16'h005A, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd6,  16'h0000, 16'h00A5, 1'b0));
        foreach (tbl[k]) begin
            start_txn(tbl[k]);
            wait_ack(lat, d, e);
            ex = exp_q.pop_front();
            total++; if (lat !== 2) begin bad++; $display("FAIL lanes[%0d] latency: got %0d want 2", k, lat); end
            total++; if (e !== ex.err) begin bad++; $display("FAIL lanes[%0d] err: got %b want %b", k, e, ex.err); end
            total++; if (d !== ex.data) begin bad++; $display("FAIL lanes[%0d] data: got %h want %h", k, d, ex.data); end
            drop_req();
        end
    endtask

    task automatic test_pointer();
        txn_t tbl [$];
        int lat; logic [15:0] d; logic e; exp_t ex;
        tbl.push_back(mk(1'b1, 2'b00, 4'd12, 16'h0000, REL,      1'b0));
        tbl.push_back(mk(1'b0, 2'b10, 4'd12, 16'h0000, 16'hFFFE, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd12, 16'h0000, 16'hFFFE, 1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 4'd12, 16'h0000, 16'hFFFE, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd12, 16'h0000, 16'h0000, 1'b0));
        tbl.push_back(mk(1'b1, 2'b01, 4'd14, 16'hFFFF, REL,      1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd14, 16'h0000, 16'h0001, 1'b0));
        tbl.push_back(mk(1'b1, 2'b10, 4'd15, 16'h1111, REL,      1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd15, 16'h0000, 16'h1111, 1'b0));
        tbl.push_back(mk(1'b0, 2'b10, 4'd15, 16'h0000, 16'h110F, 1'b0));
        foreach (tbl[k]) begin
            start_txn(tbl[k]);
            wait_ack(lat, d, e);
            ex = exp_q.pop_front();
            total++; if (lat !== 2) begin bad++; $display("FAIL ptr[%0d] latency: got %0d want 2", k, lat); end
            total++; if (e !== ex.err) begin bad++; $display("FAIL ptr[%0d] err: got %b want %b", k, e, ex.err); end
            total++; if (d !== ex.data) begin bad++; $display("FAIL ptr[%0d] data: got %h want %h", k, d, ex.data); end
            drop_req();
        end
    endtask

    task automatic test_errors();
        txn_t tbl [$];
        int lat; logic [15:0] d; logic e; exp_t ex;
        tbl.push_back(mk(1'b1, 2'b00, 4'd13, 16'hBEEF, REL,      1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 4'd8,  16'h0000, REL,      1'b1));
        tbl.push_back(mk(1'b1, 2'b01, 4'd8,  16'h9999, REL,      1'b1));
        tbl.push_back(mk(1'b1, 2'b11, 4'd13, 16'h5555, REL,      1'b1));
        tbl.push_back(mk(1'b0, 2'b11, 4'd13, 16'h0000, REL,      1'b1));
        tbl.push_back(mk(1'b0, 2'b10, 4'd0,  16'h0000, REL,      1'b1));
        tbl.push_back(mk(1'b0, 2'b00, 4'd8,  16'h0000, 16'h1234, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd13, 16'h0000, 16'hBEEF, 1'b0));
        foreach (tbl[k]) begin
            start_txn(tbl[k]);
            wait_ack(lat, d, e);
            ex = exp_q.pop_front();
            total++; if (lat !== 2) begin bad++; $display("FAIL err[%0d] latency: got %0d want 2", k, lat); end
            total++; if (e !== ex.err) begin bad++; $display("FAIL err[%0d] err: got %b want %b", k, e, ex.err); end
            total++; if (d !== ex.data) begin bad++; $display("FAIL err[%0d] data: got %h want %h", k, d, ex.data); end
            drop_req();
        end
    endtask

    task automatic test_hold();
        int lat; logic [15:0] d; logic e; exp_t ex;
        // SP is 0 here; a held post-increment read must bump it only once
        start_txn(mk(1'b0, 2'b01, 4'd12, 16'h0000, 16'h0000, 1'b0));
        wait_ack(lat, d, e);
        ex = exp_q.pop_front();
        total++; if (lat !== 2) begin bad++; $display("FAIL hold latency: got %0d want 2", lat); end
        total++; if (d !== ex.data) begin bad++; $display("FAIL hold data: got %h want %h", d, ex.data); end
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            total++; if (ACK !== 1'b1) begin bad++; $display("FAIL hold_ack[%0d]: got %b want 1", c, ACK); end
            total++; if (DATA !== 16'h0000) begin bad++; $display("FAIL hold_data[%0d]: got %h want 0000", c, DATA); end
        end
        drop_req();
        total++; if (ACK !== 1'b0) begin bad++; $display("FAIL drop_ack: got %b want 0", ACK); end
        total++; if (DATA !== REL) begin bad++; $display("FAIL drop_data: got %h want %h", DATA, REL); end
        start_txn(mk(1'b0, 2'b00, 4'd12, 16'h0000, 16'h0002, 1'b0));
        wait_ack(lat, d, e);
        ex = exp_q.pop_front();
        total++; if (lat !== 2) begin bad++; $display("FAIL b2b latency: got %0d want 2", lat); end
        total++; if (d !== ex.data) begin bad++; $display("FAIL b2b data: got %h want %h", d, ex.data); end
        drop_req();
    endtask

    task automatic test_reset_exec();
        txn_t tbl [$];
        int lat; logic [15:0] d; logic e; exp_t ex;
        start_txn(mk(1'b1, 2'b00, 4'd14, 16'h7777, REL, 1'b0));
        @(posedge CLK); #1;
        tb_drv = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        exp_q.delete();
        total++; if (ACK !== 1'b0) begin bad++; $display("FAIL rst_exec_ack: got %b want 0", ACK); end
        total++; if (DATA !== REL) begin bad++; $display("FAIL rst_exec_data: got %h want %h", DATA, REL); end
        @(negedge CLK);
        RST = 1'b0; REQ = 1'b0;
        tbl.push_back(mk(1'b0, 2'b00, 4'd14, 16'h0000, 16'h0000, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd8,  16'h0000, 16'h0000, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 4'd13, 16'h0000, 16'h0000, 1'b0));
        foreach (tbl[k]) begin
            start_txn(tbl[k]);
            wait_ack(lat, d, e);
            ex = exp_q.pop_front();
            total++; if (lat !== 2) begin bad++; $display("FAIL post_rst[%0d] latency: got %0d want 2", k, lat); end
            total++; if (d !== ex.data) begin bad++; $display("FAIL post_rst[%0d] data: got %h want %h", k, d, ex.data); end
            drop_req();
        end
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_pointer();
        test_errors();
        test_hold();
        test_reset_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
